// File: rtl/add_sub_pkg.sv
// Shared definitions for the serial adder/subtractor family: FSM encoding and
// sizing helpers derived from WIDTH and CHUNK.
package add_sub_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic int unsigned nchunk(input int unsigned width, input int unsigned chunk);
        return width / chunk;
    endfunction

    // Counter width for n chunks; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit ripple adder. Also exposes the carry into the top bit
// so callers can derive signed overflow.
module add_chunk #(
    parameter int unsigned CHUNK = 1
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK:0] c;

    always_comb begin
        s    = '0;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign cout     = c[CHUNK];
    assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/serial_add_sub.sv
// Multi-cycle two's-complement adder/subtractor: CHUNK bits per clock with a
// start/busy/done handshake, reporting carry (no-borrow on sub) and signed overflow.
module serial_add_sub
    import add_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int unsigned CW     = cnt_width(NCHUNK);

    if (WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_bad_param
        $error("serial_add_sub: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic             sub_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;

    logic [CHUNK-1:0] sum_chunk;
    logic             c_out;
    logic             c_msb;
    logic [WIDTH-1:0] acc_next;

    add_chunk #(
        .CHUNK(CHUNK)
    ) u_add_chunk (
        .x       (a_q[CHUNK-1:0]),
        .y       (b_q[CHUNK-1:0] ^ {CHUNK{sub_q}}),
        .cin     (carry_q),
        .s       (sum_chunk),
        .cout    (c_out),
        .c_msb_in(c_msb)
    );

    // Sum chunks enter at the top so the first (least significant) chunk ends at bit 0.
    assign acc_next = (WIDTH'(sum_chunk) << (WIDTH - CHUNK)) | (acc_q >> CHUNK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        sub_q   <= sub;
                        carry_q <= sub;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_q     <= a_q >> CHUNK;
                    b_q     <= b_q >> CHUNK;
                    acc_q   <= acc_next;
                    carry_q <= c_out;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CW'(NCHUNK - 1)) begin
                        result  <= acc_next;
                        cout    <= c_out;
                        ovf     <= c_msb ^ c_out;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
